// File: rtl/slurm32_cpu_memory_access.sv
// rtl/slurm32_cpu_memory_access.sv - load/store bus master stage with req/ack handshake and timeout abort
module slurm32_cpu_memory_access #(
    parameter int BITS           = 32,
    parameter int ADDRESS_BITS   = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    load_memory,
    input  logic                    store_memory,
    input  logic [ADDRESS_BITS-1:0] load_store_address,
    input  logic [BITS-1:0]         memory_out,
    input  logic [3:0]              memory_mask,
    input  logic                    load_signed,
    output logic                    stall,
    output logic                    load_valid,
    output logic [BITS-1:0]         load_data,
    output logic                    bus_error,
    output logic                    bus_req,
    output logic                    bus_wr,
    output logic [ADDRESS_BITS-1:0] bus_addr,
    output logic [BITS-1:0]         bus_wdata,
    output logic [3:0]              bus_mask,
    input  logic                    bus_ack,
    input  logic [BITS-1:0]         bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDRESS_BITS-1:0] WORD_ALIGN = {{(ADDRESS_BITS-2){1'b1}}, 2'b00};

    state_t     state;
    logic [7:0] count;
    logic       signed_q;
    logic       request;

    assign request = load_memory | store_memory;

    // Right-justify the enabled lanes of a returned word and extend to full width.
    // Irregular masks pass the word through untouched.
    function automatic logic [BITS-1:0] extract(input logic [BITS-1:0] w,
                                                input logic [3:0]      m,
                                                input logic            s);
        logic [BITS-1:0] r;
        r = w;
        case (m)
            4'b0001: r = {{(BITS-8){s & w[7]}},   w[7:0]};
            4'b0010: r = {{(BITS-8){s & w[15]}},  w[15:8]};
            4'b0100: r = {{(BITS-8){s & w[23]}},  w[23:16]};
            4'b1000: r = {{(BITS-8){s & w[31]}},  w[31:24]};
            4'b0011: r = {{(BITS-16){s & w[15]}}, w[15:0]};
            4'b1100: r = {{(BITS-16){s & w[31]}}, w[31:16]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Pipeline hold: follows the request in IDLE, forced while the bus is busy, released in DONE.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = request;
            REQ:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Transaction FSM with registered bus fields and writeback pulses.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state      <= IDLE;
            count      <= 8'd0;
            signed_q   <= 1'b0;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_mask   <= 4'b0000;
            load_valid <= 1'b0;
            load_data  <= '0;
            bus_error  <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        if (memory_mask != 4'b0000) begin
                            bus_req   <= 1'b1;
                            bus_wr    <= store_memory;
                            bus_addr  <= load_store_address & WORD_ALIGN;
                            bus_wdata <= memory_out;
                            bus_mask  <= memory_mask;
                            signed_q  <= load_signed;
                            count     <= 8'(TIMEOUT_CYCLES);
                            state     <= REQ;
                        end else begin
                            // Nothing to transfer: retire with an all-zero word.
                            if (!store_memory) begin
                                load_valid <= 1'b1;
                                load_data  <= '0;
                            end
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        // An ack on the last permitted cycle still wins over the abort.
                        bus_req <= 1'b0;
                        state   <= DONE;
                        if (!bus_wr) begin
                            load_valid <= 1'b1;
                            load_data  <= extract(bus_rdata, bus_mask, signed_q);
                        end
                    end else if (count <= 8'd1) begin
                        bus_req   <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= DONE;
                        if (!bus_wr) begin
                            load_valid <= 1'b1;
                            load_data  <= extract('1, bus_mask, signed_q);
                        end
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                // Request inputs still show the retiring instruction here; ignore them.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
